// File: rtl/challenge_expand.sv
// challenge_expand
//
// Purpose: derives the challenge lists used for signature assembly from the
// 256-bit challenge hash h_t. It reads the hash MSB-first with Picnic-style
// rejection sampling:
//   LC: 4 distinct round indices (0..7). Each is taken from a 3-bit chunk, and
//       duplicates are dropped.
//   LP: 4 party indices (0..15). Each is taken from a 4-bit chunk, and
//       duplicates are allowed.
// If the hash runs out of bits before both lists are full, expand_err is set.
// Any entries that were never filled read 0.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-high reset
//   expand_start level request, sampled only in IDLE
//   h_t_i        challenge hash, must stay stable while busy
//   lc           {LC[0],LC[1],LC[2],LC[3]}, 5-bit zero-extended entries
//   lp           {LP[0],LP[1],LP[2],LP[3]}, 5-bit zero-extended entries
//   expand_busy  high in every state except IDLE
//   expand_end   completion flag, held until expand_start drops
//   expand_err   hash exhausted; valid while expand_end is high
//
// Configuration macro: CHAL_SORT_EN. When defined, a 6-cycle bubble network
// sorts LC ascending and carries each LP entry along with its LC partner.

module challenge_expand (
    input  logic         clk,
    input  logic         reset,
    input  logic         expand_start,
    input  logic [255:0] h_t_i,
    output logic [19:0]  lc,
    output logic [19:0]  lp,
    output logic         expand_busy,
    output logic         expand_end,
    output logic         expand_err
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LC   = 3'd1;
    localparam logic [2:0] ST_LP   = 3'd2;
`ifdef CHAL_SORT_EN
    localparam logic [2:0] ST_SORT = 3'd3;
`endif
    localparam logic [2:0] ST_DONE = 3'd4;

    // Last pointer values that still leave a full chunk in the hash.
    localparam logic [8:0] LC_PTR_MAX = 9'd253;
    localparam logic [8:0] LP_PTR_MAX = 9'd252;

    logic [2:0] r_state, w_state_n;
    logic [8:0] r_ptr,   w_ptr_n;
    logic [2:0] r_cnt,   w_cnt_n;   // LC entries found, then LP index k
    logic       r_end,   w_end_n;
    logic       r_err,   w_err_n;
    logic [2:0] r_lc   [4];
    logic [2:0] w_lc_n [4];
    logic [3:0] r_lp   [4];
    logic [3:0] w_lp_n [4];

    logic [2:0] w_lc_chunk;
    logic [3:0] w_lp_chunk;
    logic       w_dup;

`ifdef CHAL_SORT_EN
    logic [2:0] r_step, w_step_n;
    logic [1:0] w_sa;
    logic [1:0] w_sb;
`endif

    // Chunk at bit pointer ptr, counted from the MSB. This is equivalent to
    // h_t_i[255-ptr -: W]. The value is meaningless once the pointer check
    // fails, but it is not used in that case.
    assign w_lc_chunk = 3'(h_t_i >> (LC_PTR_MAX - r_ptr));
    assign w_lp_chunk = 4'(h_t_i >> (LP_PTR_MAX - r_ptr));

    // Compare only against the LC entries collected so far.
    always_comb begin
        w_dup = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if ((3'(i) < r_cnt) && (r_lc[i] == w_lc_chunk)) begin
                w_dup = 1'b1;
            end
        end
    end

`ifdef CHAL_SORT_EN
    // Network pairs (0,1),(1,2),(2,3),(0,1),(1,2),(0,1): lower index per step.
    always_comb begin
        case (r_step)
            3'd0:    w_sa = 2'd0;
            3'd1:    w_sa = 2'd1;
            3'd2:    w_sa = 2'd2;
            3'd3:    w_sa = 2'd0;
            3'd4:    w_sa = 2'd1;
            default: w_sa = 2'd0;
        endcase
        w_sb = w_sa + 2'd1;
    end
`endif

    always_comb begin
        w_state_n = r_state;
        w_ptr_n   = r_ptr;
        w_cnt_n   = r_cnt;
        w_end_n   = r_end;
        w_err_n   = r_err;
        w_lc_n    = r_lc;
        w_lp_n    = r_lp;
`ifdef CHAL_SORT_EN
        w_step_n  = r_step;
`endif

        unique case (r_state)
            ST_IDLE: begin
                if (expand_start && !r_end) begin
                    w_ptr_n   = '0;
                    w_cnt_n   = '0;
                    w_err_n   = 1'b0;
                    w_lc_n    = '{default: '0};
                    w_lp_n    = '{default: '0};
`ifdef CHAL_SORT_EN
                    w_step_n  = '0;
`endif
                    w_state_n = ST_LC;
                end else if (!expand_start) begin
                    w_end_n = 1'b0;
                end
            end

            ST_LC: begin
                if (r_ptr > LC_PTR_MAX) begin
                    w_err_n   = 1'b1;
                    w_state_n = ST_DONE;
                end else begin
                    w_ptr_n = r_ptr + 9'd3;
                    if (!w_dup) begin
                        w_lc_n[r_cnt[1:0]] = w_lc_chunk;
                        if (r_cnt == 3'd3) begin
                            // Counter is reused as the LP index.
                            w_cnt_n   = '0;
                            w_state_n = ST_LP;
                        end else begin
                            w_cnt_n = r_cnt + 3'd1;
                        end
                    end
                end
            end

            ST_LP: begin
                if (r_ptr > LP_PTR_MAX) begin
                    w_err_n   = 1'b1;
                    w_state_n = ST_DONE;
                end else begin
                    w_ptr_n            = r_ptr + 9'd4;
                    w_lp_n[r_cnt[1:0]] = w_lp_chunk;
                    w_cnt_n            = r_cnt + 3'd1;
                    if (r_cnt == 3'd3) begin
`ifdef CHAL_SORT_EN
                        w_state_n = ST_SORT;
`else
                        w_state_n = ST_DONE;
`endif
                    end
                end
            end

`ifdef CHAL_SORT_EN
            ST_SORT: begin
                if (r_lc[w_sa] > r_lc[w_sb]) begin
                    w_lc_n[w_sa] = r_lc[w_sb];
                    w_lc_n[w_sb] = r_lc[w_sa];
                    w_lp_n[w_sa] = r_lp[w_sb];
                    w_lp_n[w_sb] = r_lp[w_sa];
                end
                w_step_n = r_step + 3'd1;
                if (r_step == 3'd5) begin
                    w_state_n = ST_DONE;
                end
            end
`endif

            ST_DONE: begin
                w_end_n   = 1'b1;
                w_state_n = ST_IDLE;
            end

            default: begin
                w_state_n = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_cnt   <= '0;
            r_end   <= 1'b0;
            r_err   <= 1'b0;
            r_lc    <= '{default: '0};
            r_lp    <= '{default: '0};
`ifdef CHAL_SORT_EN
            r_step  <= '0;
`endif
        end else begin
            r_state <= w_state_n;
            r_ptr   <= w_ptr_n;
            r_cnt   <= w_cnt_n;
            r_end   <= w_end_n;
            r_err   <= w_err_n;
            r_lc    <= w_lc_n;
            r_lp    <= w_lp_n;
`ifdef CHAL_SORT_EN
            r_step  <= w_step_n;
`endif
        end
    end

    assign lc = {2'b00, r_lc[0], 2'b00, r_lc[1], 2'b00, r_lc[2], 2'b00, r_lc[3]};
    assign lp = {1'b0, r_lp[0], 1'b0, r_lp[1], 1'b0, r_lp[2], 1'b0, r_lp[3]};

    assign expand_busy = (r_state != ST_IDLE);
    assign expand_end  = r_end;
    assign expand_err  = r_err;

endmodule

// File: tb/tb_challenge_expand.sv
// Testbench for challenge_expand. Expected results come from a behavioural
// model of the sampling rules. They are pushed to a queue when a run starts
// and popped when expand_end rises.

module tb_challenge_expand;

    logic         clk;
    logic         reset;
    logic         expand_start;
    logic [255:0] h_t_i;
    logic [19:0]  lc;
    logic [19:0]  lp;
    logic         expand_busy;
    logic         expand_end;
    logic         expand_err;

    typedef struct {
        logic [19:0] lc;
        logic [19:0] lp;
        logic        err;
        int          lat;
    } exp_t;

    exp_t q_exp[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    challenge_expand u_dut (
        .clk          (clk),
        .reset        (reset),
        .expand_start (expand_start),
        .h_t_i        (h_t_i),
        .lc           (lc),
        .lp           (lp),
        .expand_busy  (expand_busy),
        .expand_end   (expand_end),
        .expand_err   (expand_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    // Behavioural model of the sampling rules, including cycle latency.
    task automatic model(input logic [255:0] h, output exp_t e);
        int         ptr;
        int         cnt;
        int         edges;
        logic [2:0] l[4];
        logic [3:0] p[4];
        logic [2:0] ch;
        logic       dup;
        int         pa[6];
        logic [2:0] tl;
        logic [3:0] tp;
        ptr = 0; cnt = 0; edges = 0; e.err = 1'b0;
        for (int i = 0; i < 4; i++) begin l[i] = '0; p[i] = '0; end
        while (cnt < 4 && !e.err) begin
            edges++;
            if (ptr > 253) e.err = 1'b1;
            else begin
                ch  = 3'(h >> (253 - ptr));
                ptr += 3;
                dup = 1'b0;
                for (int j = 0; j < cnt; j++) if (l[j] == ch) dup = 1'b1;
                if (!dup) begin l[cnt] = ch; cnt++; end
            end
        end
        for (int k = 0; k < 4 && !e.err; k++) begin
            edges++;
            if (ptr > 252) e.err = 1'b1;
            else begin
                p[k] = 4'(h >> (252 - ptr));
                ptr += 4;
            end
        end
`ifdef CHAL_SORT_EN
        if (!e.err) begin
            pa = '{0, 1, 2, 0, 1, 0};
            for (int s = 0; s < 6; s++) begin
                if (l[pa[s]] > l[pa[s] + 1]) begin
                    tl = l[pa[s]]; l[pa[s]] = l[pa[s] + 1]; l[pa[s] + 1] = tl;
                    tp = p[pa[s]]; p[pa[s]] = p[pa[s] + 1]; p[pa[s] + 1] = tp;
                end
            end
            edges += 6;
        end
`endif
        edges++;
        e.lat = edges;
        e.lc  = {2'b0, l[0], 2'b0, l[1], 2'b0, l[2], 2'b0, l[3]};
        e.lp  = {1'b0, p[0], 1'b0, p[1], 1'b0, p[2], 1'b0, p[3]};
    endtask

    // Drop start for one cycle, then start a run. Start is left high on return.
    task automatic run_op(input string tag, input logic [255:0] h);
        exp_t e;
        exp_t got;
        int   cyc;
        @(negedge clk);
        expand_start = 1'b0;
        h_t_i        = h;
        @(negedge clk);
        expand_start = 1'b1;
        model(h, e);
        q_exp.push_back(e);
        @(posedge clk);  // edge N
        cyc = 0;
        while (1) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == 1) check_eq({tag, "_busy"}, 32'(expand_busy), 32'd1);
            if (expand_end) break;
            if (cyc >= 200) break;
        end
        check_eq({tag, "_end_seen"}, 32'(expand_end), 32'd1);
        if (q_exp.size() == 0) begin
            check_eq({tag, "_queue"}, 32'd0, 32'd1);
        end else begin
            got = q_exp.pop_front();
            check_eq({tag, "_lat"}, 32'(cyc), 32'(got.lat));
            check_eq({tag, "_lc"},  32'(lc),  32'(got.lc));
            check_eq({tag, "_lp"},  32'(lp),  32'(got.lp));
            check_eq({tag, "_err"}, 32'(expand_err), 32'(got.err));
        end
    endtask

    logic [255:0] v1, v2, v4, vr;

    initial begin
        v1 = {12'b000_001_010_011, 16'hFE10, 228'b0};
        v2 = {18'b101_101_111_000_101_010, 16'h3A5C, 222'b0};
        v4 = {243'b0, 9'b001_010_011, 4'b1011};

        reset        = 1'b1;
        expand_start = 1'b0;
        h_t_i        = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_lc",   32'(lc), 32'd0);
        check_eq("rst_lp",   32'(lp), 32'd0);
        check_eq("rst_busy", 32'(expand_busy), 32'd0);
        check_eq("rst_end",  32'(expand_end), 32'd0);
        check_eq("rst_err",  32'(expand_err), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Abort a run mid-LC_SCAN.
        h_t_i        = v1;
        expand_start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("abort_busy_pre", 32'(expand_busy), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_eq("abort_lc",   32'(lc), 32'd0);
        check_eq("abort_busy", 32'(expand_busy), 32'd0);
        check_eq("abort_end",  32'(expand_end), 32'd0);
        @(negedge clk);
        reset        = 1'b0;
        expand_start = 1'b0;

        run_op("v1", v1);
`ifndef CHAL_SORT_EN
        check_eq("v1_lc_const", 32'(lc), 32'({5'd0, 5'd1, 5'd2, 5'd3}));
        check_eq("v1_lp_const", 32'(lp), 32'({5'd15, 5'd14, 5'd1, 5'd0}));
`endif
        // Holding start high must keep expand_end set and must not restart.
        repeat (4) @(posedge clk);
        #1;
        check_eq("hold_end",  32'(expand_end), 32'd1);
        check_eq("hold_busy", 32'(expand_busy), 32'd0);
        @(negedge clk);
        expand_start = 1'b0;
        @(posedge clk);
        #1;
        check_eq("drop_end", 32'(expand_end), 32'd0);
        run_op("v1_again", v1);

        run_op("v2", v2);
`ifdef CHAL_SORT_EN
        check_eq("v2_lc_const", 32'(lc), 32'({5'd0, 5'd2, 5'd5, 5'd7}));
        check_eq("v2_lp_const", 32'(lp), 32'({5'd5, 5'd12, 5'd3, 5'd10}));
`else
        check_eq("v2_lc_const", 32'(lc), 32'({5'd5, 5'd7, 5'd0, 5'd2}));
        check_eq("v2_lp_const", 32'(lp), 32'({5'd3, 5'd10, 5'd5, 5'd12}));
`endif
        run_op("zero", 256'd0);
        check_eq("zero_err_const", 32'(expand_err), 32'd1);
        run_op("lp_err", v4);

        for (int r = 0; r < 4; r++) begin
            for (int w = 0; w < 8; w++) vr[w*32 +: 32] = $urandom;
            run_op($sformatf("rnd%0d", r), vr);
        end

        check_eq("queue_empty", 32'(q_exp.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/challenge_expand.md
# challenge_expand

Derives the challenge lists for signature assembly from the 256-bit challenge hash h_t. It produces 4 distinct challenged round indices (LC, rounds 0..7) and 4 matching party indices (LP, parties 0..15) using Picnic-style rejection sampling. Its `lc`/`lp` outputs and completion flag feed the signature-assembly stage directly downstream, which consumes the packed lists and starts when `expand_end` is high.

## Interface
Parameters: none (sizes fixed: 8 rounds, 4 challenges, 16 parties).
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- expand_start  input  1  level request; sampled only in IDLE
- h_t_i  input  256  challenge hash; must stay stable while busy
- lc  output  20  {LC[0],LC[1],LC[2],LC[3]}, 5-bit entries, zero-extended 3-bit round index; LC[0] in bits 19:15
- lp  output  20  {LP[0],LP[1],LP[2],LP[3]}, 5-bit entries, zero-extended 4-bit party index
- expand_busy  output  1  high in any state except IDLE
- expand_end  output  1  completion flag, held until `expand_start` drops
- expand_err  output  1  hash bits exhausted before the lists were complete; valid while `expand_end` is high

## Operation
- States: IDLE, LC_SCAN, LP_SCAN, SORT (only with the macro), DONE.
- IDLE: if `expand_start` and not `expand_end`, clear `lc`, `lp`, `expand_err`, the 9-bit bit pointer `ptr`, and the counters, then go to LC_SCAN.
- LC_SCAN, one 3-bit chunk per cycle:
  - chunk = h_t_i[255-ptr -: 3]; ptr += 3.
  - If the chunk differs from every LC entry collected so far, store it at LC[cnt] and increment cnt.
  - Duplicates are discarded.
  - When cnt reaches 4, go to LP_SCAN with the next cycle.
  - Before extracting, if ptr > 253 (fewer than 3 bits left): set `expand_err`, go to DONE.
- LP_SCAN, one 4-bit chunk per cycle:
  - LP[k] = h_t_i[255-ptr -: 4]; ptr += 4; k = 0..3.
  - Duplicates are allowed.
  - If ptr > 252 before an extraction: set `expand_err`, go to DONE.
  - After LP[3] is stored, go to SORT or DONE.
- DONE: set `expand_end`, go to IDLE. `expand_end` stays high while `expand_start` stays high; `expand_start` low clears `expand_end` on the next edge.
- Entries not filled because of an error read 0.
- Reset mid-operation returns to IDLE with all outputs 0.
- `expand_start` dropping mid-scan has no effect until DONE.

## Timing
- Reset values: `lc`=0, `lp`=0, `expand_busy`=0, `expand_end`=0, `expand_err`=0.
- The edge that samples start is edge N. With c LC chunks examined, LC_SCAN occupies edges N+1..N+c and LP_SCAN edges N+c+1..N+c+4. DONE registers `expand_end` at edge N+c+5. The minimum latency is 9 cycles (c=4).
- Error path: `expand_end` and `expand_err` go high one edge after the failing pointer check.
- `lc` and `lp` are stable from `expand_end` rising until the next start in IDLE.
- A new operation cannot begin until `expand_end` has been cleared (start low for at least 1 cycle).

## Configuration
- CHAL_SORT_EN defined:
  - SORT runs a fixed 6-cycle bubble network: compare-swap pairs (0,1),(1,2),(2,3),(0,1),(1,2),(0,1), one pair per cycle.
  - It orders LC ascending and swaps the LP entries alongside their LC partners.
  - Latency increases by 6 (`expand_end` at edge N+c+11).
  - SORT is skipped on the error path.
- CHAL_SORT_EN undefined: no SORT state; entries stay in discovery order.

## Test plan
- Reset asserted mid-LC_SCAN -> all outputs 0 next cycle; a following start runs a normal expansion.
- h_t_i[255:244]=12'b000_001_010_011, h_t_i[243:228]=16'hFE10, rest 0 -> `lc`={5'd0,5'd1,5'd2,5'd3}, `lp`={5'd15,5'd14,5'd1,5'd0}, `expand_end` at N+9, err=0.
- Leading chunks 5,5,7,0,5,2 -> `lc`={5,7,0,2}; `expand_end` at N+11 (c=6); with CHAL_SORT_EN: `lc`={0,2,5,7}, LP permuted with it, end at N+17.
- h_t_i=0 -> LC[0]=0 only, 85 chunks consumed, `expand_err`=1, `lc`=0, `lp`=0, `expand_end` at N+87.
- `expand_start` held high after done -> `expand_end` stays 1 and no restart; start low for 1 cycle then high -> a fresh run with the same results.
